// File: rtl/cube_color_loader_if.sv
// Sticker-code stream between the cube state logic (master) and the colour loader (slave).
interface cube_color_loader_if #(
    parameter int unsigned CODE_W = 3
);
    logic              s_valid;
    logic              s_ready;
    logic [CODE_W-1:0] s_code;
    logic              s_last;

    modport master (output s_valid, output s_code, output s_last, input s_ready);
    modport slave  (input s_valid, input s_code, input s_last, output s_ready);
endinterface

// File: rtl/cube_color_loader.sv
// Assembles a serial stream of sticker codes into a shadow image and publishes it on a frame boundary.
// Optional macro COLOR_CHECK_EN: reject images carrying codes 110/111.
module cube_color_loader #(
    parameter int unsigned NUM_STICKERS = 54,
    parameter int unsigned CODE_W       = 3,
    parameter int unsigned OUT_W        = NUM_STICKERS * CODE_W
) (
    input  logic               clk,
    input  logic               rst,
    cube_color_loader_if.slave s,
    input  logic               frame_done,
    output logic [OUT_W-1:0]   color,
    output logic               color_update,
    output logic               busy,
    output logic               err
);
    localparam int unsigned IDX_W = $clog2(NUM_STICKERS + 1);

    typedef enum logic [1:0] {
        ST_LOAD    = 2'b01,
        ST_PENDING = 2'b10
    } state_t;

    // Solved cube: face f (9 stickers each) shows colour code f.
    function automatic logic [OUT_W-1:0] solved_image();
        logic [OUT_W-1:0] img;
        img = '0;
        for (int unsigned k = 0; k < NUM_STICKERS; k++) begin
            img[CODE_W*k +: CODE_W] = CODE_W'(k / 9);
        end
        return img;
    endfunction

    localparam logic [OUT_W-1:0] SOLVED = solved_image();

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [OUT_W-1:0]   shadow_q, shadow_d;
    logic [OUT_W-1:0]   color_q, color_d;
    logic               color_update_q, color_update_d;
    logic               err_q, err_d;
    logic               bad_code;
    logic               at_last;

`ifdef COLOR_CHECK_EN
    assign bad_code = (s.s_code >= CODE_W'(6));
`else
    assign bad_code = 1'b0;
`endif

    assign at_last = (idx_q == IDX_W'(NUM_STICKERS - 1));

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        shadow_d       = shadow_q;
        color_d        = color_q;
        color_update_d = 1'b0;
        err_d          = 1'b0;
        s.s_ready      = 1'b0;

        case (state_q)
            ST_LOAD: begin
                s.s_ready = 1'b1;
                if (s.s_valid) begin
                    // Misplaced s_last or a missing one both discard the partial image.
                    if (bad_code || (s.s_last != at_last)) begin
                        err_d = 1'b1;
                        idx_d = '0;
                    end else begin
                        shadow_d[CODE_W*idx_q +: CODE_W] = s.s_code;
                        idx_d = idx_q + IDX_W'(1);
                        if (at_last) begin
                            state_d = ST_PENDING;
                        end
                    end
                end
            end
            ST_PENDING: begin
                if (frame_done) begin
                    color_d        = shadow_q;
                    color_update_d = 1'b1;
                    idx_d          = '0;
                    state_d        = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_LOAD;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_LOAD;
            idx_q          <= '0;
            shadow_q       <= '0;
            color_q        <= SOLVED;
            color_update_q <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            shadow_q       <= shadow_d;
            color_q        <= color_d;
            color_update_q <= color_update_d;
            err_q          <= err_d;
        end
    end

    assign color        = color_q;
    assign color_update = color_update_q;
    assign err          = err_q;
    assign busy         = (state_q == ST_PENDING) || (idx_q != '0);
endmodule
